// File: rtl/pipe_ctrl_unit_if.sv
// ID-to-EX control handshake bundle for pipe_ctrl_unit.
// master drives the ID side, slave is the control unit.
interface pipe_ctrl_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  instr_valid_id;
  logic [6:0]            opcode_id;
  logic [6:0]            funct7_id;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  branch_taken_ex;
  logic                  stall_if_id;
  logic                  flush_if_id;
  logic                  ex_valid;
  logic                  ex_alusrc;
  logic                  ex_memtoreg;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_pcr;
  logic [1:0]            ex_aluop;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_muldiv;
  logic                  ex_illegal;
  logic                  muldiv_done;

  modport master (
    output instr_valid_id, opcode_id, funct7_id,
    output rs1_id, rs2_id, rd_id, branch_taken_ex,
    input  stall_if_id, flush_if_id, ex_valid,
    input  ex_alusrc, ex_memtoreg, ex_regwrite,
    input  ex_memread, ex_memwrite, ex_branch,
    input  ex_jump, ex_pcr, ex_aluop, ex_rd,
    input  ex_muldiv, ex_illegal, muldiv_done
  );

  modport slave (
    input  instr_valid_id, opcode_id, funct7_id,
    input  rs1_id, rs2_id, rd_id, branch_taken_ex,
    output stall_if_id, flush_if_id, ex_valid,
    output ex_alusrc, ex_memtoreg, ex_regwrite,
    output ex_memread, ex_memwrite, ex_branch,
    output ex_jump, ex_pcr, ex_aluop, ex_rd,
    output ex_muldiv, ex_illegal, muldiv_done
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ID decode, ID/EX control register and hazard control
// (load-use, taken branch flush, multi-cycle M ops).
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int ENABLE_M   = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  pipe_ctrl_unit_if.slave bus
);
  localparam int CW = $clog2(MULDIV_LAT + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(MULDIV_LAT - 1);

  typedef struct packed {
    logic                  valid;
    logic                  alusrc;
    logic                  memtoreg;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  branch;
    logic                  jump;
    logic                  pcr;
    logic [1:0]            aluop;
    logic [REG_ADDR_W-1:0] rd;
    logic                  muldiv;
    logic                  illegal;
  } ex_ctrl_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ex_ctrl_t      ex_q, dec;

  logic is_r, is_lw, is_sw, is_i, is_br;
  logic is_jal, is_jalr, is_auipc, is_lui;
  logic hold, luse, load, br;

  // Decode the ID-stage opcode into a control bundle
  always_comb begin
    is_r     = bus.opcode_id == 7'b0110011;
    is_lw    = bus.opcode_id == 7'b0000011;
    is_sw    = bus.opcode_id == 7'b0100011;
    is_i     = bus.opcode_id == 7'b0010011;
    is_br    = bus.opcode_id == 7'b1100011;
    is_jal   = bus.opcode_id == 7'b1101111;
    is_jalr  = bus.opcode_id == 7'b1100111;
    is_auipc = bus.opcode_id == 7'b0010111;
    is_lui   = bus.opcode_id == 7'b0110111;
    dec          = '0;
    dec.valid    = 1'b1;
    dec.alusrc   = is_lw | is_sw | is_i | is_auipc
                 | is_lui | is_jal | is_jalr;
    dec.memtoreg = is_lw | is_auipc;
    dec.regwrite = is_r | is_lw | is_i | is_auipc
                 | is_lui | is_jal | is_jalr;
    dec.memread  = is_lw;
    dec.memwrite = is_sw;
    dec.aluop[0] = is_br | is_i;
    dec.aluop[1] = is_r | is_i;
    dec.branch   = is_br | is_jal;
    dec.jump     = is_jalr;
    dec.pcr      = is_jal | is_jalr | is_auipc;
    dec.rd       = bus.rd_id;
    dec.muldiv   = (ENABLE_M != 0) && is_r
                 && (bus.funct7_id == 7'b0000001);
    dec.illegal  = !(is_r | is_lw | is_sw | is_i | is_br
                 | is_jal | is_jalr | is_auipc | is_lui);
  end

  // Hazard detection and pipeline control outputs
  always_comb begin
    br   = bus.branch_taken_ex;
    hold = (state_q == BUSY) && (cnt_q != '0);
    luse = ex_q.valid && ex_q.memread && (ex_q.rd != '0)
        && ((ex_q.rd == bus.rs1_id) || (ex_q.rd == bus.rs2_id))
        && bus.instr_valid_id;
    load = !hold && !br && !luse && bus.instr_valid_id;
    bus.stall_if_id = !reset && (hold || (luse && !br));
    bus.flush_if_id = !reset && br && !hold;
    bus.muldiv_done = (state_q == BUSY) && (cnt_q == '0);
  end

  // M-op occupancy FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load && dec.muldiv) begin
          state_d = BUSY;
          cnt_d   = CNT_LD;
        end
      end
      BUSY: begin
        if (hold) begin
          cnt_d = cnt_q - CW'(1);
        end else if (load && dec.muldiv) begin
          cnt_d = CNT_LD;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ID/EX control register: hold, bubble or load
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else if (!hold) begin
      ex_q <= load ? dec : '0;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_alusrc   = ex_q.alusrc;
  assign bus.ex_memtoreg = ex_q.memtoreg;
  assign bus.ex_regwrite = ex_q.regwrite;
  assign bus.ex_memread  = ex_q.memread;
  assign bus.ex_memwrite = ex_q.memwrite;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_jump     = ex_q.jump;
  assign bus.ex_pcr      = ex_q.pcr;
  assign bus.ex_aluop    = ex_q.aluop;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_muldiv   = ex_q.muldiv;
  assign bus.ex_illegal  = ex_q.illegal;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard cases then
// random traffic against a cycle-level reference model.
module tb_pipe_ctrl_unit;
  localparam int RW  = 5;
  localparam int LAT = 4;
  localparam logic [6:0] OP_R = 7'h33, OP_LW = 7'h03;
  localparam logic [6:0] OP_SW = 7'h23, OP_I = 7'h13;
  localparam logic [6:0] OP_BR = 7'h63, OP_JAL = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67, OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LUI = 7'h37;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.REG_ADDR_W(RW)) bus ();

  pipe_ctrl_unit #(
    .REG_ADDR_W(RW),
    .ENABLE_M(1),
    .MULDIV_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: EX bundle and remaining cycles of the M op in EX
  logic [17:0] m_ex = '0;
  int          m_left = 0;

  logic [17:0] last_ex;
  logic        last_stall, last_flush, last_done;
  int          n_st, n_dn, n_md;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp,
               $time);
    end
  endtask

  // {valid, alusrc, memtoreg, regwrite, memread, memwrite,
  //  branch, jump, pcr, aluop[1:0], rd[4:0], muldiv, illegal}
  function automatic logic [17:0] ref_dec(
      input logic [6:0] op, input logic [6:0] f7,
      input logic [4:0] rd);
    logic [7:0] c;
    logic [1:0] a;
    logic md, il;
    md = 1'b0;
    il = 1'b0;
    case (op)
      OP_R:     begin c = 8'b0010_0000; a = 2'b10;
                      md = (f7 == 7'b0000001); end
      OP_LW:    begin c = 8'b1111_0000; a = 2'b00; end
      OP_SW:    begin c = 8'b1000_1000; a = 2'b00; end
      OP_I:     begin c = 8'b1010_0000; a = 2'b11; end
      OP_BR:    begin c = 8'b0000_0100; a = 2'b01; end
      OP_JAL:   begin c = 8'b1010_0101; a = 2'b00; end
      OP_JALR:  begin c = 8'b1010_0011; a = 2'b00; end
      OP_AUIPC: begin c = 8'b1110_0001; a = 2'b00; end
      OP_LUI:   begin c = 8'b1010_0000; a = 2'b00; end
      default:  begin c = 8'h00; a = 2'b00; il = 1'b1; end
    endcase
    return {1'b1, c, a, rd, md, il};
  endfunction

  task automatic drv(input logic v, input logic [6:0] op,
                     input logic [6:0] f7, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd,
                     input logic br);
    bus.instr_valid_id  = v;
    bus.opcode_id       = op;
    bus.funct7_id       = f7;
    bus.rs1_id          = r1;
    bus.rs2_id          = r2;
    bus.rd_id           = rd;
    bus.branch_taken_ex = br;
  endtask

  // compare at negedge, then advance the model at posedge
  task automatic cyc();
    logic [17:0] obs;
    logic hold, luse, br, v;
    @(negedge clk);
    br   = bus.branch_taken_ex;
    v    = bus.instr_valid_id;
    hold = m_left > 1;
    luse = m_ex[17] && m_ex[13] && (m_ex[6:2] != 0)
        && (m_ex[6:2] == bus.rs1_id || m_ex[6:2] == bus.rs2_id)
        && v;
    obs = {bus.ex_valid, bus.ex_alusrc, bus.ex_memtoreg,
           bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
           bus.ex_branch, bus.ex_jump, bus.ex_pcr, bus.ex_aluop,
           bus.ex_rd, bus.ex_muldiv, bus.ex_illegal};
    chk("ex_bundle", 32'(obs), 32'(m_ex));
    chk("stall", 32'(bus.stall_if_id),
        32'(!reset && (hold || (luse && !br))));
    chk("flush", 32'(bus.flush_if_id),
        32'(!reset && br && !hold));
    chk("muldiv_done", 32'(bus.muldiv_done), 32'(m_left == 1));
    last_ex    = obs;
    last_stall = bus.stall_if_id;
    last_flush = bus.flush_if_id;
    last_done  = bus.muldiv_done;
    n_st += int'(bus.stall_if_id);
    n_dn += int'(bus.muldiv_done);
    n_md += int'(bus.ex_muldiv);
    @(posedge clk);
    if (reset) begin
      m_ex = '0;
      m_left = 0;
    end else if (hold) begin
      m_left--;
    end else if (br || luse || !v) begin
      m_ex = '0;
      m_left = 0;
    end else begin
      m_ex = ref_dec(bus.opcode_id, bus.funct7_id, bus.rd_id);
      m_left = m_ex[1] ? LAT : 0;
    end
    #1;
  endtask

  initial begin
    int k;
    logic [6:0] op, f7;
    drv(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc();
    reset = 1'b0;

    // load-use on x5
    drv(1, OP_LW, 0, 2, 0, 5, 0); cyc();
    drv(1, OP_R, 0, 5, 1, 6, 0); cyc();
    chk("luse_stall", 32'(last_stall), 1);
    chk("luse_bubble_next", 32'(last_ex[17]), 1);
    cyc();
    chk("luse_bubble", 32'(last_ex[17]), 0);
    drv(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("add_regwrite", 32'(last_ex[14]), 1);

    // load to x0 never stalls
    drv(1, OP_LW, 0, 2, 0, 0, 0); cyc();
    drv(1, OP_R, 0, 0, 1, 6, 0); cyc();
    chk("lw_x0_nostall", 32'(last_stall), 0);

    // MUL occupies EX for LAT cycles
    drv(1, OP_R, 7'b0000001, 1, 2, 3, 0); cyc();
    drv(1, OP_I, 0, 1, 0, 7, 0);
    n_st = 0; n_dn = 0; n_md = 0;
    repeat (LAT) cyc();
    chk("mul_stalls", 32'(n_st), LAT - 1);
    chk("mul_done", 32'(n_dn), 1);
    chk("mul_ex_muldiv", 32'(n_md), LAT);

    // taken branch squashes MUL in ID
    drv(1, OP_BR, 0, 1, 2, 0, 0); cyc();
    drv(1, OP_R, 7'b0000001, 1, 2, 3, 1); cyc();
    chk("br_flush", 32'(last_flush), 1);
    drv(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("br_bubble", 32'(last_ex[17]), 0);
    cyc();
    chk("br_no_mstall", 32'(last_stall | last_done), 0);

    // JAL and illegal decode
    drv(1, OP_JAL, 0, 0, 0, 1, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("jal_ctrl", 32'(last_ex[16:9]), 32'h0000_00a5);
    drv(1, 7'h7f, 0, 0, 0, 1, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("illegal", 32'(last_ex[0]), 1);

    // reset in second hold cycle of MUL
    drv(1, OP_R, 7'b0000001, 1, 2, 3, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0); cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; cyc();
    chk("rst_ex_clear", 32'(last_ex), 0);
    chk("rst_no_stall", 32'(last_stall | last_done), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 10);
      f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      case (k)
        0: op = OP_R;    1: op = OP_LW;   2: op = OP_SW;
        3: op = OP_I;    4: op = OP_BR;   5: op = OP_JAL;
        6: op = OP_JALR; 7: op = OP_AUIPC; 8: op = OP_LUI;
        9: begin op = OP_R; f7 = 7'b0000001; end
        default: op = 7'($urandom);
      endcase
      drv(($urandom_range(0, 7) != 0), op, f7,
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)),
          (m_left <= 1) && ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 63) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
